// File: rtl/sal_cmd_sched.sv
// Channel command scheduler: arbitrates per-bank ACT/RD/WR/PRE/REF requests under
// inter-bank timing limits and issues one registered DRAM command per cycle.
module sal_cmd_sched #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned RA_W      = 16,
    parameter int unsigned CA_W      = 10,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned TW        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TW-1:0]              t_rrd_i,
    input  logic [TW-1:0]              t_ccd_i,
    input  logic [TW-1:0]              t_wtr_i,
    input  logic [TW-1:0]              t_rtw_i,
    input  logic [NUM_BANKS-1:0]       act_req_i,
    input  logic [NUM_BANKS-1:0]       rd_req_i,
    input  logic [NUM_BANKS-1:0]       wr_req_i,
    input  logic [NUM_BANKS-1:0]       pre_req_i,
    input  logic [NUM_BANKS-1:0]       ref_req_i,
    input  logic [NUM_BANKS*RA_W-1:0]  ra_i,
    input  logic [NUM_BANKS*CA_W-1:0]  ca_i,
    input  logic [NUM_BANKS*ID_W-1:0]  id_i,
    input  logic [NUM_BANKS*LEN_W-1:0] len_i,
    output logic [NUM_BANKS-1:0]       act_gnt_o,
    output logic [NUM_BANKS-1:0]       rd_gnt_o,
    output logic [NUM_BANKS-1:0]       wr_gnt_o,
    output logic [NUM_BANKS-1:0]       pre_gnt_o,
    output logic [NUM_BANKS-1:0]       ref_gnt_o,
    output logic                       cmd_valid_o,
    output logic [2:0]                 cmd_o,
    output logic [BA_W-1:0]            cmd_ba_o,
    output logic [RA_W-1:0]            cmd_ra_o,
    output logic [CA_W-1:0]            cmd_ca_o,
    output logic [ID_W-1:0]            cmd_id_o,
    output logic [LEN_W-1:0]           cmd_len_o
);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    logic [TW-1:0]   rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BA_W-1:0] cas_ptr, act_ptr, pre_ptr, ref_ptr;

    logic [RA_W-1:0]  ra_a  [NUM_BANKS];
    logic [CA_W-1:0]  ca_a  [NUM_BANKS];
    logic [ID_W-1:0]  id_a  [NUM_BANKS];
    logic [LEN_W-1:0] len_a [NUM_BANKS];

    logic                 act_ok, rd_ok, wr_ok;
    logic [NUM_BANKS-1:0] cas_elig, act_elig;
    logic [BA_W:0]        cas_pick, act_pick, pre_pick, ref_pick;

    cmd_e             nxt_cmd;
    logic [BA_W-1:0]  sel_ba;
    logic             nxt_cas;
    logic [RA_W-1:0]  nxt_ra;
    logic [CA_W-1:0]  nxt_ca;
    logic [ID_W-1:0]  nxt_id;
    logic [LEN_W-1:0] nxt_len;

    // First requesting bank at or after ptr, wrapping; MSB flags a hit.
    function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                              input logic [BA_W-1:0] ptr);
        logic [BA_W:0]   res;
        logic [BA_W-1:0] idx;
        res = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            idx = ptr + BA_W'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Counter reload value t-1, clamped so 0 and 1 both mean back-to-back.
    function automatic logic [TW-1:0] ld_val(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            ra_a[b]  = ra_i[b*RA_W +: RA_W];
            ca_a[b]  = ca_i[b*CA_W +: CA_W];
            id_a[b]  = id_i[b*ID_W +: ID_W];
            len_a[b] = len_i[b*LEN_W +: LEN_W];
        end
    end

    assign act_ok   = (rrd_cnt == '0);
    assign rd_ok    = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok    = (ccd_cnt == '0) && (rtw_cnt == '0);
    // A bank showing both RD and WR is treated as RD only.
    assign cas_elig = (rd_req_i & {NUM_BANKS{rd_ok}})
                    | (wr_req_i & ~rd_req_i & {NUM_BANKS{wr_ok}});
    assign act_elig = act_req_i & {NUM_BANKS{act_ok}};

    assign cas_pick = rr_pick(cas_elig,  cas_ptr);
    assign act_pick = rr_pick(act_elig,  act_ptr);
    assign pre_pick = rr_pick(pre_req_i, pre_ptr);
    assign ref_pick = rr_pick(ref_req_i, ref_ptr);

    // Class arbitration CAS > ACT > PRE > REF and grant decode.
    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        nxt_cmd   = CMD_NOP;
        sel_ba    = '0;
        if (cas_pick[BA_W]) begin
            sel_ba = cas_pick[BA_W-1:0];
            if (rd_req_i[sel_ba]) begin
                nxt_cmd          = CMD_RD;
                rd_gnt_o[sel_ba] = 1'b1;
            end else begin
                nxt_cmd          = CMD_WR;
                wr_gnt_o[sel_ba] = 1'b1;
            end
        end else if (act_pick[BA_W]) begin
            sel_ba            = act_pick[BA_W-1:0];
            nxt_cmd           = CMD_ACT;
            act_gnt_o[sel_ba] = 1'b1;
        end else if (pre_pick[BA_W]) begin
            sel_ba            = pre_pick[BA_W-1:0];
            nxt_cmd           = CMD_PRE;
            pre_gnt_o[sel_ba] = 1'b1;
        end else if (ref_pick[BA_W]) begin
            sel_ba            = ref_pick[BA_W-1:0];
            nxt_cmd           = CMD_REF;
            ref_gnt_o[sel_ba] = 1'b1;
        end
    end

    assign nxt_cas = (nxt_cmd == CMD_RD) || (nxt_cmd == CMD_WR);
    assign nxt_ra  = (nxt_cmd != CMD_NOP && !nxt_cas) ? ra_a[sel_ba] : '0;
    assign nxt_ca  = nxt_cas ? ca_a[sel_ba] : '0;
    assign nxt_len = nxt_cas ? len_a[sel_ba] : '0;
    assign nxt_id  = (nxt_cmd != CMD_NOP) ? id_a[sel_ba] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
            cmd_ba_o    <= '0;
            cmd_ra_o    <= '0;
            cmd_ca_o    <= '0;
            cmd_id_o    <= '0;
            cmd_len_o   <= '0;
        end else begin
            cmd_valid_o <= (nxt_cmd != CMD_NOP);
            cmd_o       <= nxt_cmd;
            cmd_ba_o    <= sel_ba;
            cmd_ra_o    <= nxt_ra;
            cmd_ca_o    <= nxt_ca;
            cmd_id_o    <= nxt_id;
            cmd_len_o   <= nxt_len;
        end
    end

    // Timing counters: reload on the constraining grant, else count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
        end else begin
            if (nxt_cmd == CMD_ACT)  rrd_cnt <= ld_val(t_rrd_i);
            else if (rrd_cnt != '0)  rrd_cnt <= rrd_cnt - TW'(1);
            if (nxt_cas)             ccd_cnt <= ld_val(t_ccd_i);
            else if (ccd_cnt != '0)  ccd_cnt <= ccd_cnt - TW'(1);
            if (nxt_cmd == CMD_WR)   wtr_cnt <= ld_val(t_wtr_i);
            else if (wtr_cnt != '0)  wtr_cnt <= wtr_cnt - TW'(1);
            if (nxt_cmd == CMD_RD)   rtw_cnt <= ld_val(t_rtw_i);
            else if (rtw_cnt != '0)  rtw_cnt <= rtw_cnt - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cas_ptr <= '0;
            act_ptr <= '0;
            pre_ptr <= '0;
            ref_ptr <= '0;
        end else begin
            if (nxt_cas)             cas_ptr <= sel_ba + BA_W'(1);
            if (nxt_cmd == CMD_ACT)  act_ptr <= sel_ba + BA_W'(1);
            if (nxt_cmd == CMD_PRE)  pre_ptr <= sel_ba + BA_W'(1);
            if (nxt_cmd == CMD_REF)  ref_ptr <= sel_ba + BA_W'(1);
        end
    end

endmodule
